// File: rtl/io_bridge_demux_if.sv
// CPU-side request/response and device-side strobe/readback bundle for io_bridge_demux.
// The bridge takes the slave modport; the CPU/device model side takes master.
interface io_bridge_demux_if;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic        cpu_re;
    logic        cpu_ready;
    logic        cpu_done;
    logic        cpu_err;
    logic [31:0] cpu_rdata;
    logic [1:0]  dev_addr;
    logic [31:0] dev_wdata;
    logic        dev0_we;
    logic        dev1_we;
    logic [31:0] dev0_rdata;
    logic [31:0] dev1_rdata;
    logic        dev0_irq;
    logic        dev1_irq;
    logic [5:0]  hwint;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, cpu_re,
        input  dev0_rdata, dev1_rdata, dev0_irq, dev1_irq,
        output cpu_ready, cpu_done, cpu_err, cpu_rdata,
        output dev_addr, dev_wdata, dev0_we, dev1_we, hwint
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_we, cpu_re,
        output dev0_rdata, dev1_rdata, dev0_irq, dev1_irq,
        input  cpu_ready, cpu_done, cpu_err, cpu_rdata,
        input  dev_addr, dev_wdata, dev0_we, dev1_we, hwint
    );
endinterface

// File: rtl/io_bridge_demux.sv
// Routes one MEM-stage load/store to the timer (dev 0) or output port (dev 1),
// returns registered read data and exports registered device interrupts.
//
//   state  | meaning
//   IDLE   | ready; latch a request on the next edge (write wins over read)
//   ACCESS | drive dev_addr/dev_wdata, pulse the decoded strobe, capture read data
//   RESP   | one-cycle cpu_done with latched err and captured read data
module io_bridge_demux #(
    parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
    parameter logic [31:0] DEV1_BASE = 32'h0000_7F10,
    parameter int unsigned DEV_WORDS = 3
) (
    input  logic             clk,
    input  logic             reset,
    io_bridge_demux_if.slave bus
);

    localparam logic [31:0] SPAN     = 32'(4 * DEV_WORDS);
    localparam logic [31:0] DEV0_END = DEV0_BASE + SPAN;
    localparam logic [31:0] DEV1_END = DEV1_BASE + SPAN;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        wr_q;
    logic [31:0] rdata_q;
    logic [5:0]  hwint_q;

    logic        aligned;
    logic        hit0;
    logic        hit1;
    logic        err;
    logic [1:0]  offset;
    logic [31:0] rdata_sel;

    always_comb begin
        aligned = (addr_q[1:0] == 2'b00);
        hit0    = aligned && (addr_q >= DEV0_BASE) && (addr_q < DEV0_END);
        hit1    = aligned && (addr_q >= DEV1_BASE) && (addr_q < DEV1_END);
        err     = !(hit0 || hit1);
        // Bases are word aligned, so the low word-offset bits of (addr - base) depend only on bits [3:2].
        offset  = 2'b00;
        if (hit0) begin
            offset = addr_q[3:2] - DEV0_BASE[3:2];
        end else if (hit1) begin
            offset = addr_q[3:2] - DEV1_BASE[3:2];
        end
        rdata_sel = 32'h0;
        if (hit0) begin
            rdata_sel = bus.dev0_rdata;
        end else if (hit1) begin
            rdata_sel = bus.dev1_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cpu_we || bus.cpu_re) begin
                    accept    = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wr_q    <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            if (accept) begin
                addr_q  <= bus.cpu_addr;
                wdata_q <= bus.cpu_wdata;
                wr_q    <= bus.cpu_we;
            end
            if (state == ACCESS) begin
                rdata_q <= wr_q ? 32'h0 : rdata_sel;
            end
        end
    end

    // Interrupts are a plain one-cycle delay, independent of the request FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hwint_q <= 6'b0;
        end else begin
            hwint_q <= {4'b0000, bus.dev1_irq, bus.dev0_irq};
        end
    end

    // Outputs decode from state only, so an async reset kills a strobe at once.
    always_comb begin
        bus.cpu_ready = (state == IDLE);
        bus.cpu_done  = (state == RESP);
        bus.cpu_err   = (state == RESP) && err;
        bus.cpu_rdata = (state == RESP) ? rdata_q : 32'h0;
        bus.dev_addr  = (state == ACCESS) ? offset : 2'b00;
        bus.dev_wdata = (state == ACCESS) ? wdata_q : 32'h0;
        bus.dev0_we   = (state == ACCESS) && wr_q && hit0;
        bus.dev1_we   = (state == ACCESS) && wr_q && hit1;
        bus.hwint     = hwint_q;
    end

endmodule

// File: tb/tb_io_bridge_demux.sv
// Directed bench for io_bridge_demux: scoreboard of expected responses checked on cpu_done,
// plus strobe, decode, reset and interrupt checks at fixed points.
module tb_io_bridge_demux;

    localparam logic [31:0] D0    = 32'h0000_7F00;
    localparam logic [31:0] D1    = 32'h0000_7F10;
    localparam int          WORDS = 3;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        logic        we0;
        logic        we1;
        logic [1:0]  daddr;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int tests    = 0;
    int fails    = 0;
    int we0_cnt  = 0;
    int done_cnt = 0;

    exp_t sb[$];

    logic [31:0] dev0_mem [4];
    logic [31:0] dev1_mem [4];

    io_bridge_demux_if bus ();

    io_bridge_demux dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.dev0_rdata = dev0_mem[bus.dev_addr];
    assign bus.dev1_rdata = dev1_mem[bus.dev_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic w, input logic [31:0] a);
        exp_t        e;
        logic [31:0] span;
        logic        h0;
        logic        h1;
        span    = 32'(4 * WORDS);
        h0      = (a[1:0] == 2'b00) && (a >= D0) && (a < D0 + span);
        h1      = (a[1:0] == 2'b00) && (a >= D1) && (a < D1 + span);
        e.err   = !(h0 || h1);
        e.we0   = w && h0;
        e.we1   = w && h1;
        e.daddr = 2'b00;
        if (h0) e.daddr = 2'((a - D0) >> 2);
        if (h1) e.daddr = 2'((a - D1) >> 2);
        e.rdata = 32'h0;
        if (!w && h0) e.rdata = dev0_mem[e.daddr];
        if (!w && h1) e.rdata = dev1_mem[e.daddr];
        return e;
    endfunction

    // Response monitor: every cpu_done pops one expectation; idle cycles must show zero err/rdata.
    always @(negedge clk) begin
        exp_t e;
        if (bus.dev0_we === 1'b1) we0_cnt++;
        tests++;
        assert (!(bus.dev0_we === 1'b1 && bus.dev1_we === 1'b1)) else begin
            fails++;
            $error("FAIL strobe_exclusive: observed dev0_we=%b dev1_we=%b expected at most one", bus.dev0_we, bus.dev1_we);
        end
        if (bus.cpu_done === 1'b1) begin
            done_cnt++;
            tests++;
            assert (sb.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_done: observed done with %0d pending expected >0 pending", sb.size());
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("resp_err", 32'(bus.cpu_err), 32'(e.err));
                check("resp_rdata", bus.cpu_rdata, e.rdata);
            end
        end else begin
            check("idle_err", 32'(bus.cpu_err), 32'h0);
            check("idle_rdata", bus.cpu_rdata, 32'h0);
        end
    end

    task automatic req(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   n;
        check("ready_before_req", 32'(bus.cpu_ready), 32'h1);
        bus.cpu_we    = w;
        bus.cpu_re    = r;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        e = model(w, a);
        sb.push_back(e);
        @(negedge clk);
        check("access_dev0_we", 32'(bus.dev0_we), 32'(e.we0));
        check("access_dev1_we", 32'(bus.dev1_we), 32'(e.we1));
        check("access_ready", 32'(bus.cpu_ready), 32'h0);
        check("access_wdata", bus.dev_wdata, d);
        if (!e.err) check("access_dev_addr", 32'(bus.dev_addr), 32'(e.daddr));
        bus.cpu_we = 1'b0;
        bus.cpu_re = 1'b0;
        n = 1;
        while (bus.cpu_done !== 1'b1 && n < 6) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, 2);
        @(negedge clk);
        check("ready_after", 32'(bus.cpu_ready), 32'h1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ready"}, 32'(bus.cpu_ready), 32'h1);
        check({tag, "_done"}, 32'(bus.cpu_done), 32'h0);
        check({tag, "_we0"}, 32'(bus.dev0_we), 32'h0);
        check({tag, "_we1"}, 32'(bus.dev1_we), 32'h0);
        check({tag, "_hwint"}, 32'(bus.hwint), 32'h0);
    endtask

    initial begin
        int s0;
        int d0;
        dev0_mem[0] = 32'h1111_0000;
        dev0_mem[1] = 32'h2222_0001;
        dev0_mem[2] = 32'h0000_1234;
        dev0_mem[3] = 32'h4444_0003;
        dev1_mem[0] = 32'hA5A5_0010;
        dev1_mem[1] = 32'hB6B6_0011;
        dev1_mem[2] = 32'hC7C7_0012;
        dev1_mem[3] = 32'hD8D8_0013;
        bus.cpu_we    = 1'b0;
        bus.cpu_re    = 1'b0;
        bus.cpu_addr  = 32'h0;
        bus.cpu_wdata = 32'h0;
        bus.dev0_irq  = 1'b0;
        bus.dev1_irq  = 1'b0;
        #1 reset = 1'b0;

        repeat (3) begin
            @(negedge clk);
            check_quiet("in_reset");
        end
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_quiet("idle");
        end

        req(1'b1, 1'b0, 32'h0000_7F14, 32'hDEAD_BEEF);
        req(1'b0, 1'b1, 32'h0000_7F08, 32'h0);
        req(1'b0, 1'b1, 32'h0000_7F0C, 32'h0);
        req(1'b1, 1'b0, 32'h0000_7F11, 32'h1357_9BDF);
        req(1'b1, 1'b0, 32'h0000_7F0C, 32'h0BAD_0BAD);
        req(1'b0, 1'b1, 32'h0000_7F1C, 32'h0);
        req(1'b0, 1'b1, 32'h0000_7EFC, 32'h0);
        req(1'b0, 1'b1, 32'h0000_7F18, 32'h0);
        req(1'b0, 1'b1, 32'h0000_7F10, 32'h0);
        req(1'b1, 1'b0, 32'h0000_7F04, 32'h5555_AAAA);

        // Write+read together at dev0, then a second request held through ACCESS/RESP.
        s0 = we0_cnt;
        check("prio_ready", 32'(bus.cpu_ready), 32'h1);
        bus.cpu_we    = 1'b1;
        bus.cpu_re    = 1'b1;
        bus.cpu_addr  = 32'h0000_7F00;
        bus.cpu_wdata = 32'hCAFE_0001;
        sb.push_back(model(1'b1, 32'h0000_7F00));
        @(negedge clk);
        check("prio_dev0_we", 32'(bus.dev0_we), 32'h1);
        check("prio_dev1_we", 32'(bus.dev1_we), 32'h0);
        bus.cpu_we   = 1'b0;
        bus.cpu_re   = 1'b1;
        bus.cpu_addr = 32'h0000_7F04;
        @(negedge clk);
        check("blocked_ready", 32'(bus.cpu_ready), 32'h0);
        check("blocked_done", 32'(bus.cpu_done), 32'h1);
        @(negedge clk);
        check("second_ready", 32'(bus.cpu_ready), 32'h1);
        sb.push_back(model(1'b0, 32'h0000_7F04));
        @(negedge clk);
        check("second_dev_addr", 32'(bus.dev_addr), 32'h1);
        check("second_dev0_we", 32'(bus.dev0_we), 32'h0);
        bus.cpu_re = 1'b0;
        @(negedge clk);
        check("second_done", 32'(bus.cpu_done), 32'h1);
        @(negedge clk);
        check("prio_single_pulse", we0_cnt - s0, 1);
        check("prio_sb_drained", sb.size(), 0);

        // Async reset in the middle of a write ACCESS.
        d0 = done_cnt;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 32'h0000_7F08;
        bus.cpu_wdata = 32'h7777_8888;
        @(negedge clk);
        check("rst_pre_we0", 32'(bus.dev0_we), 32'h1);
        #1 reset = 1'b0;
        #1;
        check("rst_we0_drop", 32'(bus.dev0_we), 32'h0);
        check("rst_ready", 32'(bus.cpu_ready), 32'h1);
        bus.cpu_we = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_quiet("post_rst");
        end
        check("rst_no_done", done_cnt - d0, 0);

        // Interrupt export.
        bus.dev1_irq = 1'b1;
        #1 check("irq_not_yet", 32'(bus.hwint), 32'h0);
        @(negedge clk);
        check("irq_dev1", 32'(bus.hwint), 32'h02);
        bus.dev0_irq = 1'b1;
        @(negedge clk);
        check("irq_both", 32'(bus.hwint), 32'h03);
        bus.dev0_irq = 1'b0;
        bus.dev1_irq = 1'b0;
        @(negedge clk);
        check("irq_clear", 32'(bus.hwint), 32'h00);

        check("sb_empty_end", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/io_bridge_demux.md
Name: io_bridge_demux

Overview:
- CPU-side bridge that routes one load/store request from the MEM stage to one of two memory-mapped devices. Device 0 is the timer and device 1 is the output port.
- It is the distribution counterpart of the datapath select muxes: one request in, a decoded write strobe out to exactly one device.
- Read data is returned through a registered select path.
- Device interrupt lines are registered and exported as the CP0 hardware-interrupt vector.

Parameters:
DEV0_BASE, 32'h0000_7F00, byte base address of device 0
DEV1_BASE, 32'h0000_7F10, byte base address of device 1
DEV_WORDS, 3, number of 32-bit registers per device (span = 4*DEV_WORDS bytes)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_addr  in  32  byte address of request
cpu_wdata  in  32  store data
cpu_we  in  1  store request
cpu_re  in  1  load request
cpu_ready  out  1  bridge idle, request accepted this cycle
cpu_done  out  1  one-cycle completion pulse
cpu_err  out  1  valid with cpu_done: decode miss or misaligned
cpu_rdata  out  32  load data, valid with cpu_done
dev_addr  out  2  word offset within selected device
dev_wdata  out  32  store data to devices
dev0_we  out  1  write strobe, device 0
dev1_we  out  1  write strobe, device 1
dev0_rdata  in  32  device 0 read data (combinational from dev_addr)
dev1_rdata  in  32  device 1 read data
dev0_irq  in  1  device 0 interrupt
dev1_irq  in  1  device 1 interrupt
hwint  out  6  {4'b0, dev1_irq, dev0_irq}, registered

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0 except cpu_ready=1.
  - A write strobe in flight is dropped immediately.
  - A request in flight is abandoned and no cpu_done is produced.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. No other transitions.
- IDLE:
  - cpu_ready=1.
  - If cpu_we|cpu_re on a rising edge, latch the request and go to ACCESS. The latched fields are addr, wdata and op; op = write if cpu_we=1, else read.
  - Write has priority when both cpu_we and cpu_re are 1; the read is discarded and not queued.
  - With no request, stay in IDLE.
- Decode, on the latched address:
  - Hit on device k when addr[1:0]==0 and DEVk_BASE <= addr < DEVk_BASE + 4*DEV_WORDS.
  - dev_addr = (addr - DEVk_BASE) >> 2.
  - Otherwise miss: err=1.
- ACCESS (exactly 1 cycle):
  - cpu_ready=0.
  - dev_addr and dev_wdata are driven from the latch.
  - Write hit: devk_we=1 for this cycle only; the other strobe stays 0.
  - Write miss: no strobe.
  - Read: the rdata of the selected device is captured at the end of the cycle. A miss captures 32'h0.
  - Next state is RESP.
- RESP (exactly 1 cycle):
  - cpu_done=1.
  - cpu_err = latched err.
  - cpu_rdata = captured value for a read, 0 for a write.
  - Next state is IDLE.
- Timing:
  - Latency is request edge to cpu_done = 2 cycles.
  - Throughput is one request per 3 cycles.
  - Requests asserted while cpu_ready=0 are ignored; the CPU holds its request until it sees cpu_ready.
- cpu_rdata and cpu_err are 0 in every cycle in which cpu_done=0.
- dev0_we and dev1_we are never high simultaneously.
- hwint is registered every cycle independent of the FSM: 1-cycle delay, no latching; it follows the irq inputs.
- Upper-bound check is exclusive: DEVk_BASE + 4*DEV_WORDS is a miss. The gap between devices (e.g. 0x7F0C..0x7F0F) is a miss.

Test Plan:
- Reset/idle:
  - Stimulus: hold reset=0 for 3 cycles, release, no request for 5 cycles.
  - Required: cpu_ready=1 throughout; cpu_done, dev0_we, dev1_we, hwint all 0.
- Write hit on device 1:
  - Stimulus: cpu_we=1, cpu_addr=0x7F14, cpu_wdata=0xDEADBEEF.
  - Required, next cycle: dev1_we=1, dev0_we=0, dev_addr=1, dev_wdata=0xDEADBEEF.
  - Required, following cycle: cpu_done=1, cpu_err=0, cpu_rdata=0.
  - Required, after that: cpu_ready=1.
- Read hit on device 0:
  - Stimulus: cpu_re=1, cpu_addr=0x7F08, dev0_rdata=0x0000_1234 while dev_addr=2.
  - Required: cpu_done 2 cycles after the request, with cpu_rdata=0x1234 and cpu_err=0.
- Errors:
  - Stimulus: read at 0x7F0C; write at 0x7F11 (misaligned).
  - Required: each returns cpu_done with cpu_err=1 and cpu_rdata=0; no write strobe asserted.
- Write/read priority and blocking:
  - Stimulus: cpu_we=cpu_re=1 at 0x7F00; a second request presented during ACCESS.
  - Required: only dev0_we pulses, exactly once; the second request is ignored until cpu_ready=1.
- Async reset and interrupts:
  - Stimulus: assert reset=0 mid-ACCESS of a write.
  - Required: dev0_we drops immediately and no cpu_done follows.
  - Stimulus: dev1_irq=1.
  - Required: hwint=6'b000010 one cycle later.
